// File: rtl/dma_channel.sv
// dma_channel: single-channel DMA bus master that copies half-words or words over the pipelined memory bus.
// Optional feature macro DMA_IRQ_EN: sticky completion interrupt on irq (tied low when undefined).

`ifndef MEM_SIZE_HALF
`define MEM_SIZE_HALF 2'b01
`endif
`ifndef MEM_SIZE_WORD
`define MEM_SIZE_WORD 2'b10
`endif

module dma_channel #(
    parameter int CNT_W = 14
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [31:0]      src_addr,
    input  logic [31:0]      dst_addr,
    input  logic [CNT_W-1:0] xfer_count,
    input  logic             word_mode,
    input  logic [1:0]       src_ctrl,
    input  logic [1:0]       dst_ctrl,
    input  logic             bus_grant,
    output logic [31:0]      bus_addr,
    output logic [31:0]      bus_wdata,
    input  logic [31:0]      bus_rdata,
    output logic [1:0]       bus_size,
    output logic             bus_write,
    input  logic             bus_pause,
    output logic             bus_req,
    output logic             busy,
    output logic             done,
    output logic             irq
);

    typedef enum logic [2:0] {IDLE, WAIT_GNT, RD, WR, FLUSH} state_e;

    localparam logic [CNT_W:0] REM_ONE = {{CNT_W{1'b0}}, 1'b1};
    localparam logic [CNT_W:0] REM_MAX = {1'b1, {CNT_W{1'b0}}};

    state_e         state_q, state_d;
    logic [31:0]    src_q, src_d;
    logic [31:0]    dst_q, dst_d;
    logic [CNT_W:0] rem_q, rem_d;
    logic           word_q, word_d;
    logic [1:0]     sctl_q, sctl_d;
    logic [1:0]     dctl_q, dctl_d;
    logic [31:0]    dbuf_q, dbuf_d;
    logic           done_q, done_d;

    logic [31:0]    step;
    logic [15:0]    rd_half;
    logic [1:0]     cur_size;

    assign step     = word_q ? 32'd4 : 32'd2;
    assign cur_size = word_q ? `MEM_SIZE_WORD : `MEM_SIZE_HALF;

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        word_d  = word_q;
        sctl_d  = sctl_q;
        dctl_d  = dctl_q;
        dbuf_d  = dbuf_q;
        done_d  = 1'b0;
        rd_half = src_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d   = src_addr;
                    dst_d   = dst_addr;
                    rem_d   = (xfer_count == '0) ? REM_MAX : {1'b0, xfer_count};
                    word_d  = word_mode;
                    sctl_d  = src_ctrl;
                    dctl_d  = dst_ctrl;
                    state_d = WAIT_GNT;
                end
            end
            WAIT_GNT: begin
                if (bus_grant && !bus_pause) state_d = RD;
            end
            RD: begin
                if (!bus_pause) state_d = WR;
            end
            WR: begin
                if (!bus_pause) begin
                    // Half-words migrate from the source lane to the destination lane; the other lane is zeroed.
                    dbuf_d = word_q ? bus_rdata
                                    : (dst_q[1] ? {rd_half, 16'h0000} : {16'h0000, rd_half});
                    case (sctl_q)
                        2'b00:   src_d = src_q + step;
                        2'b01:   src_d = src_q - step;
                        default: src_d = src_q;
                    endcase
                    case (dctl_q)
                        2'b01:   dst_d = dst_q - step;
                        2'b10:   dst_d = dst_q;
                        default: dst_d = dst_q + step;
                    endcase
                    rem_d   = rem_q - REM_ONE;
                    state_d = (rem_q == REM_ONE) ? FLUSH : RD;
                end
            end
            FLUSH: begin
                if (!bus_pause) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Bus outputs are a pure function of held state, so a pause freezes them automatically.
    always_comb begin
        bus_addr  = 32'h0;
        bus_wdata = 32'h0;
        bus_size  = `MEM_SIZE_HALF;
        bus_write = 1'b0;
        case (state_q)
            RD: begin
                bus_addr  = src_q;
                bus_wdata = dbuf_q;
                bus_size  = cur_size;
            end
            WR: begin
                bus_addr  = dst_q;
                bus_write = 1'b1;
                bus_size  = cur_size;
            end
            FLUSH: begin
                bus_wdata = dbuf_q;
                bus_size  = cur_size;
            end
            default: ;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign bus_req = busy;
    assign done    = done_q;

    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= 32'h0;
            dst_q   <= 32'h0;
            rem_q   <= '0;
            word_q  <= 1'b0;
            sctl_q  <= 2'b00;
            dctl_q  <= 2'b00;
            dbuf_q  <= 32'h0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            word_q  <= word_d;
            sctl_q  <= sctl_d;
            dctl_q  <= dctl_d;
            dbuf_q  <= dbuf_d;
            done_q  <= done_d;
        end
    end

`ifdef DMA_IRQ_EN
    logic irq_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else if (state_q == IDLE && start) begin
            irq_q <= 1'b0;
        end else if (done_d) begin
            irq_q <= 1'b1;
        end
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_dma_channel.sv
// tb_dma_channel: randomized self-checking bench for dma_channel with a pipelined memory slave
// and a sequential copy model computed from the transfer rules.

`ifndef MEM_SIZE_HALF
`define MEM_SIZE_HALF 2'b01
`endif
`ifndef MEM_SIZE_WORD
`define MEM_SIZE_WORD 2'b10
`endif

module tb_dma_channel;

    localparam int CNT_W = 4;
    localparam logic [1:0] SZ_HALF = `MEM_SIZE_HALF;
    localparam logic [1:0] SZ_WORD = `MEM_SIZE_WORD;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [31:0]      src_addr;
    logic [31:0]      dst_addr;
    logic [CNT_W-1:0] xfer_count;
    logic             word_mode;
    logic [1:0]       src_ctrl;
    logic [1:0]       dst_ctrl;
    logic             bus_grant;
    logic [31:0]      bus_addr;
    logic [31:0]      bus_wdata;
    logic [31:0]      bus_rdata;
    logic [1:0]       bus_size;
    logic             bus_write;
    logic             bus_pause;
    logic             bus_req;
    logic             busy;
    logic             done;
    logic             irq;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    dma_channel #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .xfer_count (xfer_count),
        .word_mode  (word_mode),
        .src_ctrl   (src_ctrl),
        .dst_ctrl   (dst_ctrl),
        .bus_grant  (bus_grant),
        .bus_addr   (bus_addr),
        .bus_wdata  (bus_wdata),
        .bus_rdata  (bus_rdata),
        .bus_size   (bus_size),
        .bus_write  (bus_write),
        .bus_pause  (bus_pause),
        .bus_req    (bus_req),
        .busy       (busy),
        .done       (done),
        .irq        (irq)
    );

    // ---------------- memory (DUT-facing) and model memory ----------------
    logic [31:0] mem [bit [29:0]];
    logic [31:0] mdl [bit [29:0]];

    function automatic logic [31:0] init_word(input logic [29:0] k);
        return {k[13:0], 2'b11, k[15:0]} ^ 32'h9e37_79b9;
    endfunction

    function automatic logic [31:0] rd_word(input bit m, input logic [31:0] a);
        bit [29:0] k;
        k = a[31:2];
        if (m) begin
            if (mdl.exists(k)) return mdl[k];
        end else begin
            if (mem.exists(k)) return mem[k];
        end
        return init_word(k);
    endfunction

    function automatic void wr_unit(input bit m, input logic [31:0] a, input logic [1:0] sz,
                                    input logic [31:0] d);
        logic [31:0] w;
        w = rd_word(m, a);
        if (sz == SZ_WORD) w = d;
        else if (a[1]) w[31:16] = d[31:16];
        else w[15:0] = d[15:0];
        if (m) mdl[a[31:2]] = w;
        else mem[a[31:2]] = w;
    endfunction

    function automatic int first_diff(input logic [31:0] got[$], input logic [31:0] want[$]);
        int lim;
        lim = (got.size() < want.size()) ? got.size() : want.size();
        for (int i = 0; i < lim; i++) if (got[i] !== want[i]) return i;
        if (got.size() != want.size()) return lim;
        return -1;
    endfunction

    // Pipelined slave: address phase in one accepted cycle, data phase in the next accepted one.
    logic        wr_pend = 1'b0;
    logic [31:0] wr_addr = 32'h0;
    logic [1:0]  wr_size = 2'b00;
    logic [31:0] prev_addr = 32'h0;
    logic [31:0] rd_log[$];
    logic [31:0] wr_log[$];
    logic [31:0] wd_log[$];

    initial bus_rdata = 32'h0;

    always @(posedge clock) begin
        if (reset) begin
            wr_pend = 1'b0;
        end else if (!bus_pause) begin
            if (wr_pend) begin
                wr_unit(1'b0, wr_addr, wr_size, bus_wdata);
                wd_log.push_back(bus_wdata);
            end
            if (bus_write) begin
                wr_log.push_back(bus_addr);
                rd_log.push_back(prev_addr);
            end
            wr_pend   = bus_write;
            wr_addr   = bus_addr;
            wr_size   = bus_size;
            prev_addr = bus_addr;
            bus_rdata <= rd_word(1'b0, bus_addr);
        end
    end

    // ---------------- one complete transfer against the model ----------------
    task automatic run_xfer(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input logic [CNT_W-1:0] cnt, input logic wm, input logic [1:0] sc,
                            input logic [1:0] dc, input int gnt_delay, input int p_off,
                            input int p_len, input bit poke);
        int          n, done_e, exp_e, di;
        logic [31:0] step, s, d, v, ew, a;
        logic [15:0] h;
        logic [31:0] exp_rd[$];
        logic [31:0] exp_wr[$];
        logic [31:0] exp_wd[$];
        logic [31:0] fz_addr, fz_wdata;
        logic        fz_write, exp_irq;

        n    = (cnt == '0) ? (1 << CNT_W) : int'(cnt);
        step = wm ? 32'd4 : 32'd2;
        mdl  = mem;
        s    = src;
        d    = dst;
        for (int i = 0; i < n; i++) begin
            v  = rd_word(1'b1, s);
            h  = s[1] ? v[31:16] : v[15:0];
            ew = wm ? v : (d[1] ? {h, 16'h0000} : {16'h0000, h});
            exp_rd.push_back(s);
            exp_wr.push_back(d);
            exp_wd.push_back(ew);
            wr_unit(1'b1, d, wm ? SZ_WORD : SZ_HALF, ew);
            if (sc == 2'b00) s = s + step;
            else if (sc == 2'b01) s = s - step;
            if (dc == 2'b01) d = d - step;
            else if (dc != 2'b10) d = d + step;
        end
        rd_log.delete();
        wr_log.delete();
        wd_log.delete();

        @(negedge clock);
        start = 1'b1; src_addr = src; dst_addr = dst; xfer_count = cnt;
        word_mode = wm; src_ctrl = sc; dst_ctrl = dc;
        @(negedge clock);
        start = 1'b0; src_addr = $urandom; dst_addr = $urandom; xfer_count = CNT_W'($urandom);

        n_checks++;
        if (busy !== 1'b1 || bus_req !== 1'b1 || bus_write !== 1'b0 || irq !== 1'b0)
            $display("FAIL %s wait_grant: busy/req/write/irq got %b%b%b%b want 1100",
                     tag, busy, bus_req, bus_write, irq);
        else n_pass++;

        for (int k = 0; k < gnt_delay; k++) begin
            if (poke && k == 0) begin
                start = 1'b1; src_addr = 32'h0bad_0000; dst_addr = 32'h0bad_1000; xfer_count = '1;
            end
            @(negedge clock);
            start = 1'b0;
        end
        bus_grant = 1'b1;

        done_e = -1;
        for (int e = 0; e < 2 * n + p_len + 20; e++) begin
            @(negedge clock);
            if (done === 1'b1) begin
                done_e = e;
                break;
            end
            bus_pause = (e >= p_off && e < p_off + p_len);
            start     = poke && (e == 1);
            if (poke && e == 1) begin
                src_addr = 32'h0bad_2000; dst_addr = 32'h0bad_3000;
            end
            if (p_len > 0 && e == p_off) begin
                fz_addr = bus_addr; fz_wdata = bus_wdata; fz_write = bus_write;
            end else if (p_len > 0 && e > p_off && e <= p_off + p_len) begin
                n_checks++;
                if (bus_addr !== fz_addr || bus_wdata !== fz_wdata || bus_write !== fz_write || busy !== 1'b1)
                    $display("FAIL %s pause_hold: addr/wdata/write got %h/%h/%b want %h/%h/%b",
                             tag, bus_addr, bus_wdata, bus_write, fz_addr, fz_wdata, fz_write);
                else n_pass++;
            end
        end
        bus_pause = 1'b0;
        start     = 1'b0;

        exp_e = 2 * n + 1 + p_len;
        n_checks++;
        if (done_e != exp_e)
            $display("FAIL %s done_latency: got %0d cycles after grant want %0d (-1 = timeout)",
                     tag, done_e, exp_e);
        else n_pass++;

`ifdef DMA_IRQ_EN
        exp_irq = 1'b1;
`else
        exp_irq = 1'b0;
`endif
        n_checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0 || irq !== exp_irq)
            $display("FAIL %s done_state: busy/req/irq got %b%b%b want 00%b", tag, busy, bus_req, irq, exp_irq);
        else n_pass++;

        bus_grant = 1'b0;
        @(negedge clock);
        n_checks++;
        if (done !== 1'b0) $display("FAIL %s done_pulse_width: done got %b want 0", tag, done);
        else n_pass++;

        di = first_diff(rd_log, exp_rd);
        n_checks++;
        if (di >= 0)
            $display("FAIL %s read_addrs: at unit %0d got %h want %h (sizes %0d/%0d)", tag, di,
                     (di < rd_log.size()) ? rd_log[di] : 32'hx, (di < exp_rd.size()) ? exp_rd[di] : 32'hx,
                     rd_log.size(), exp_rd.size());
        else n_pass++;

        di = first_diff(wr_log, exp_wr);
        n_checks++;
        if (di >= 0)
            $display("FAIL %s write_addrs: at unit %0d got %h want %h (sizes %0d/%0d)", tag, di,
                     (di < wr_log.size()) ? wr_log[di] : 32'hx, (di < exp_wr.size()) ? exp_wr[di] : 32'hx,
                     wr_log.size(), exp_wr.size());
        else n_pass++;

        di = first_diff(wd_log, exp_wd);
        n_checks++;
        if (di >= 0)
            $display("FAIL %s write_data: at unit %0d got %h want %h (sizes %0d/%0d)", tag, di,
                     (di < wd_log.size()) ? wd_log[di] : 32'hx, (di < exp_wd.size()) ? exp_wd[di] : 32'hx,
                     wd_log.size(), exp_wd.size());
        else n_pass++;

        di = -1;
        foreach (exp_wr[i]) if (di < 0 && rd_word(1'b0, exp_wr[i]) !== rd_word(1'b1, exp_wr[i])) di = i;
        a = (di >= 0) ? exp_wr[di] : 32'h0;
        n_checks++;
        if (di >= 0)
            $display("FAIL %s dest_memory: word at %h got %h want %h", tag, a, rd_word(1'b0, a), rd_word(1'b1, a));
        else n_pass++;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if ({bus_addr, bus_wdata, bus_size, bus_write, bus_req, busy, done, irq} !==
            {32'h0, 32'h0, SZ_HALF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_values: addr=%h wdata=%h size=%b write=%b req=%b busy=%b done=%b irq=%b",
                     bus_addr, bus_wdata, bus_size, bus_write, bus_req, busy, done, irq);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clock);
        n_checks++;
        if (busy !== 1'b0 || bus_req !== 1'b0 || done !== 1'b0)
            $display("FAIL idle_after_reset: busy/req/done got %b%b%b want 000", busy, bus_req, done);
        else n_pass++;
    endtask

    task automatic test_word_copy();
        mem[30'h00c0_0000] = 32'hdead_beef;
        mem[30'h00c0_0001] = 32'hcafe_f00d;
        run_xfer("word_copy", 32'h0300_0000, 32'h0600_0000, 4'd2, 1'b1, 2'b00, 2'b00, 2, 0, 0, 1'b0);
        n_checks++;
        if (rd_word(1'b0, 32'h0600_0000) !== 32'hdead_beef || rd_word(1'b0, 32'h0600_0004) !== 32'hcafe_f00d)
            $display("FAIL word_copy_vram: got %h %h want deadbeef cafef00d",
                     rd_word(1'b0, 32'h0600_0000), rd_word(1'b0, 32'h0600_0004));
        else n_pass++;
    endtask

    task automatic test_half_swap();
        mem[30'h0140_0000] = 32'h1234_ba11;
        mem[30'h01c0_0010] = 32'h5555_6666;
        run_xfer("half_swap", 32'h0500_0000, 32'h0700_0042, 4'd1, 1'b0, 2'b00, 2'b00, 0, 0, 0, 1'b0);
        n_checks++;
        if (wd_log.size() != 1 || wd_log[0] !== 32'hba11_0000)
            $display("FAIL half_swap_wdata: got %h want ba110000", (wd_log.size() > 0) ? wd_log[0] : 32'hx);
        else n_pass++;
        n_checks++;
        if (rd_word(1'b0, 32'h0700_0040) !== 32'hba11_6666)
            $display("FAIL half_swap_oam: got %h want ba116666", rd_word(1'b0, 32'h0700_0040));
        else n_pass++;
    endtask

    task automatic test_fixed_dec();
        run_xfer("fixed_dec", 32'h0300_0100, 32'h0600_0008, 4'd3, 1'b1, 2'b10, 2'b01, 1, 0, 0, 1'b0);
        n_checks++;
        if (wr_log.size() != 3 || wr_log[0] !== 32'h0600_0008 || wr_log[1] !== 32'h0600_0004 ||
            wr_log[2] !== 32'h0600_0000 || rd_log[0] !== 32'h0300_0100 || rd_log[2] !== 32'h0300_0100)
            $display("FAIL fixed_dec_addrs: got %0d writes, first %h want 0x06000008..0x06000000 / src 03000100",
                     wr_log.size(), (wr_log.size() > 0) ? wr_log[0] : 32'hx);
        else n_pass++;
    endtask

    task automatic test_pause();
        run_xfer("pause", 32'h0300_0200, 32'h0600_0200, 4'd2, 1'b1, 2'b00, 2'b00, 1, 3, 3, 1'b0);
    endtask

    task automatic test_count_zero();
        run_xfer("count_zero", 32'h0300_0400, 32'h0600_0400, 4'd0, 1'b1, 2'b00, 2'b00, 0, 0, 0, 1'b0);
        n_checks++;
        if (wr_log.size() != 16) $display("FAIL count_zero_units: got %0d want 16", wr_log.size());
        else n_pass++;
    endtask

    task automatic test_wrap();
        run_xfer("wrap", 32'hffff_fffc, 32'h0600_0100, 4'd2, 1'b1, 2'b00, 2'b00, 0, 0, 0, 1'b0);
    endtask

    task automatic test_start_busy();
        run_xfer("start_busy", 32'h0300_0300, 32'h0600_0302, 4'd3, 1'b0, 2'b00, 2'b00, 2, 0, 0, 1'b1);
    endtask

    task automatic test_reset_mid();
        int dcount;
        @(negedge clock);
        start = 1'b1; src_addr = 32'h0300_0200; dst_addr = 32'h0600_0600; xfer_count = 4'd3;
        word_mode = 1'b1; src_ctrl = 2'b00; dst_ctrl = 2'b00;
        @(negedge clock);
        start = 1'b0;
        bus_grant = 1'b1;
        repeat (3) @(negedge clock);
        n_checks++;
        if (bus_addr !== 32'h0300_0204 || bus_write !== 1'b0)
            $display("FAIL reset_mid_second_read: addr got %h want 03000204", bus_addr);
        else n_pass++;
        reset = 1'b1;
        @(negedge clock);
        n_checks++;
        if ({bus_addr, bus_wdata, bus_size, bus_write, bus_req, busy, done, irq} !==
            {32'h0, 32'h0, SZ_HALF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0})
            $display("FAIL reset_mid_values: addr=%h wdata=%h size=%b write=%b req=%b busy=%b done=%b irq=%b",
                     bus_addr, bus_wdata, bus_size, bus_write, bus_req, busy, done, irq);
        else n_pass++;
        reset = 1'b0;
        bus_grant = 1'b0;
        dcount = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            if (done === 1'b1 || busy === 1'b1) dcount++;
        end
        n_checks++;
        if (dcount != 0) $display("FAIL reset_mid_no_done: done/busy seen %0d cycles want 0", dcount);
        else n_pass++;
        run_xfer("after_reset", 32'h0300_0500, 32'h0600_0700, 4'd2, 1'b0, 2'b00, 2'b00, 1, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0]      s, d;
        logic [CNT_W-1:0] c;
        logic             wm;
        int               n;
        for (int it = 0; it < 10; it++) begin
            wm = 1'($urandom_range(0, 1));
            s  = 32'h0300_0800 | ($urandom & (wm ? 32'h0000_0ffc : 32'h0000_0ffe));
            d  = 32'h0600_0800 | ($urandom & (wm ? 32'h0000_0ffc : 32'h0000_0ffe));
            n  = $urandom_range(1, 6);
            c  = CNT_W'(n);
            run_xfer($sformatf("random%0d", it), s, d, c, wm, 2'($urandom), 2'($urandom),
                     $urandom_range(0, 3), $urandom_range(0, 2 * n), $urandom_range(0, 3),
                     1'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; src_addr = 32'h0; dst_addr = 32'h0; xfer_count = '0;
        word_mode = 1'b0; src_ctrl = 2'b00; dst_ctrl = 2'b00; bus_grant = 1'b0; bus_pause = 1'b0;
        test_reset();
        test_word_copy();
        test_half_swap();
        test_fixed_dec();
        test_pause();
        test_count_zero();
        test_wrap();
        test_start_busy();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish within the time limit");
        $fatal(1, "timeout");
    end

endmodule
